// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle integer multiply/divide function unit (execute stage).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             kills any in-flight op; beats accept and out_ready
//   in_valid/in_ready operation handshake (ready only in IDLE)
//   in_funct          decoded funct code (FUNCT_* / FUNCT2_* below)
//   in_tag            ROB tag carried to out_tag
//   in_a, in_b        rs / rt operands
//   in_hi, in_lo      current HI/LO, accumulator for MADD/MSUB family
//   out_valid/out_ready result handshake to writeback
//   out_tag           tag of the result
//   out_result        GPR result (MUL only), out_reg_we its write enable
//   out_hi, out_lo    HI/LO results, out_hilo_we their write enable
//
// Multiplies take MUL_CYCLES from accept to out_valid. Division is a 32-step
// radix-2 restoring divider on magnitudes; operand magnitudes are formed at
// accept and the sign fixup is folded into the final iteration, giving 33
// cycles from accept to out_valid.
module mul_div_unit #(
  parameter int TAG_WIDTH  = 5,
  parameter int MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_funct,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  input  logic [31:0]          in_hi,
  input  logic [31:0]          in_lo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [31:0]          out_result,
  output logic                 out_reg_we,
  output logic [31:0]          out_hi,
  output logic [31:0]          out_lo,
  output logic                 out_hilo_we
);

  // SPECIAL-space functs keep their MIPS values; SPECIAL2 ops are remapped by
  // ID into 0x30 | funct2 so the two spaces share one 6-bit code.
  localparam logic [5:0] FUNCT_MULT    = 6'h18;
  localparam logic [5:0] FUNCT_MULTU   = 6'h19;
  localparam logic [5:0] FUNCT_DIV     = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
  localparam logic [5:0] FUNCT2_MADD   = 6'h30;
  localparam logic [5:0] FUNCT2_MADDU  = 6'h31;
  localparam logic [5:0] FUNCT2_MUL    = 6'h32;
  localparam logic [5:0] FUNCT2_MSUB   = 6'h34;
  localparam logic [5:0] FUNCT2_MSUBU  = 6'h35;

  localparam int CNT_W = $clog2(MUL_CYCLES + 34);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [5:0]           op_funct;
  logic [31:0]          op_a, op_b;
  logic [63:0]          op_acc;
  logic [TAG_WIDTH-1:0] op_tag;
  logic [31:0]          div_rem, div_quo, div_d;
  logic                 q_neg, r_neg, div0;

  logic accept, in_is_mul, in_is_div, in_div_sgn, last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (cnt == CNT_W'(1));

  assign in_is_mul = (in_funct == FUNCT_MULT)  || (in_funct == FUNCT_MULTU) ||
                     (in_funct == FUNCT2_MUL)  || (in_funct == FUNCT2_MADD) ||
                     (in_funct == FUNCT2_MADDU)|| (in_funct == FUNCT2_MSUB) ||
                     (in_funct == FUNCT2_MSUBU);
  assign in_is_div  = (in_funct == FUNCT_DIV) || (in_funct == FUNCT_DIVU);
  assign in_div_sgn = (in_funct == FUNCT_DIV);

  // Multiplier sees live inputs in IDLE so MUL_CYCLES == 1 can finish at accept.
  logic [5:0]  m_funct;
  logic [31:0] m_a, m_b;
  logic [63:0] m_acc, m_xa, m_xb, m_prod, m_res;
  logic        m_sgn;

  always_comb begin
    m_funct = (state == S_IDLE) ? in_funct : op_funct;
    m_a     = (state == S_IDLE) ? in_a : op_a;
    m_b     = (state == S_IDLE) ? in_b : op_b;
    m_acc   = (state == S_IDLE) ? {in_hi, in_lo} : op_acc;
    m_sgn   = (m_funct == FUNCT_MULT) || (m_funct == FUNCT2_MUL) ||
              (m_funct == FUNCT2_MADD) || (m_funct == FUNCT2_MSUB);
    m_xa    = m_sgn ? {{32{m_a[31]}}, m_a} : {32'b0, m_a};
    m_xb    = m_sgn ? {{32{m_b[31]}}, m_b} : {32'b0, m_b};
    // Low 64 bits of the extended product are exact for both signednesses.
    m_prod  = m_xa * m_xb;
    case (m_funct)
      FUNCT2_MADD, FUNCT2_MADDU: m_res = m_acc + m_prod;
      FUNCT2_MSUB, FUNCT2_MSUBU: m_res = m_acc - m_prod;
      default:                   m_res = m_prod;
    endcase
  end

  // One restoring step plus the signed/zero-divisor result of the final step.
  logic [32:0] d_shift, d_diff;
  logic [31:0] d_rem_n, d_quo_n, d_lo, d_hi;

  always_comb begin
    d_shift = {div_rem, div_quo[31]};
    d_diff  = d_shift - {1'b0, div_d};
    if (!d_diff[32]) begin
      d_rem_n = d_diff[31:0];
      d_quo_n = {div_quo[30:0], 1'b1};
    end else begin
      d_rem_n = d_shift[31:0];
      d_quo_n = {div_quo[30:0], 1'b0};
    end
    d_lo = q_neg ? (32'd0 - d_quo_n) : d_quo_n;
    d_hi = r_neg ? (32'd0 - d_rem_n) : d_rem_n;
    if (div0) begin
      d_lo = 32'hFFFF_FFFF;
      d_hi = op_a;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) begin
        if (in_is_mul)      state_n = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
        else if (in_is_div) state_n = S_DIV;
        else                state_n = S_DONE;
      end
      S_MUL:  if (last) state_n = S_DONE;
      S_DIV:  if (last) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt         <= '0;
      op_funct    <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_acc      <= '0;
      op_tag      <= '0;
      div_rem     <= '0;
      div_quo     <= '0;
      div_d       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      div0        <= 1'b0;
      out_tag     <= '0;
      out_result  <= '0;
      out_reg_we  <= 1'b0;
      out_hi      <= '0;
      out_lo      <= '0;
      out_hilo_we <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_funct <= in_funct;
          op_a     <= in_a;
          op_b     <= in_b;
          op_acc   <= {in_hi, in_lo};
          op_tag   <= in_tag;
          out_tag  <= in_tag;
          cnt      <= in_is_div ? CNT_W'(32) : CNT_W'(MUL_CYCLES - 1);
          div_rem  <= '0;
          div_quo  <= (in_div_sgn && in_a[31]) ? (32'd0 - in_a) : in_a;
          div_d    <= (in_div_sgn && in_b[31]) ? (32'd0 - in_b) : in_b;
          q_neg    <= in_div_sgn && (in_a[31] ^ in_b[31]);
          r_neg    <= in_div_sgn && in_a[31];
          div0     <= (in_b == 32'd0);
          if (in_is_mul && MUL_CYCLES == 1) begin
            out_result  <= (in_funct == FUNCT2_MUL) ? m_res[31:0] : 32'd0;
            out_reg_we  <= (in_funct == FUNCT2_MUL);
            out_hi      <= (in_funct == FUNCT2_MUL) ? 32'd0 : m_res[63:32];
            out_lo      <= (in_funct == FUNCT2_MUL) ? 32'd0 : m_res[31:0];
            out_hilo_we <= (in_funct != FUNCT2_MUL);
          end
        end
        S_MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            out_result  <= (op_funct == FUNCT2_MUL) ? m_res[31:0] : 32'd0;
            out_reg_we  <= (op_funct == FUNCT2_MUL);
            out_hi      <= (op_funct == FUNCT2_MUL) ? 32'd0 : m_res[63:32];
            out_lo      <= (op_funct == FUNCT2_MUL) ? 32'd0 : m_res[31:0];
            out_hilo_we <= (op_funct != FUNCT2_MUL);
          end
        end
        S_DIV: begin
          cnt     <= cnt - CNT_W'(1);
          div_rem <= d_rem_n;
          div_quo <= d_quo_n;
          if (last) begin
            out_hi      <= d_hi;
            out_lo      <= d_lo;
            out_hilo_we <= 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          out_tag     <= '0;
          out_result  <= '0;
          out_reg_we  <= 1'b0;
          out_hi      <= '0;
          out_lo      <= '0;
          out_hilo_we <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: hand-computed vectors, immediate
// assertions at each comparison point.
module tb_mul_div_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MADD  = 6'h30;
  localparam logic [5:0] F_MUL   = 6'h32;
  localparam logic [5:0] F_MSUBU = 6'h35;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] in_a, in_b, in_hi, in_lo, out_result, out_hi, out_lo;
  logic        out_reg_we, out_hilo_we;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  mul_div_unit #(.TAG_WIDTH(5), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_hi(in_hi), .in_lo(in_lo),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .out_reg_we(out_reg_we), .out_hi(out_hi),
    .out_lo(out_lo), .out_hilo_we(out_hilo_we)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic [4:0] tag);
    @(negedge clk);
    in_funct = f; in_a = a; in_b = b; in_hi = hi; in_lo = lo; in_tag = tag;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_a = 32'hDEAD_BEEF; in_b = 32'hDEAD_BEEF; in_hi = 32'hDEAD_BEEF; in_lo = 32'hDEAD_BEEF;
  endtask

  // Clock edges after the accept edge until out_valid (0 => valid at t+1).
  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge with out_valid high: retire and confirm IDLE.
  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_tag = '0; in_a = '0; in_b = '0; in_hi = '0; in_lo = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_hi, out_lo}, 64'd0);
    chk("rst_we", {out_reg_we, out_hilo_we, out_tag, out_result}, '0);

    // MULT -1 * 2
    issue(F_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, 5'd1);
    wait_valid(lat);
    chk("mult_lat", lat, 2);
    chk("mult_hilo", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_we", {out_hilo_we, out_reg_we}, 2'b10);
    chk("mult_tag", out_tag, 1);
    retire("mult");

    // MULTU same operands
    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 5'd2);
    wait_valid(lat);
    chk("multu_lat", lat, 2);
    chk("multu_hilo", {out_hi, out_lo}, 64'h0000_0001_FFFF_FFFE);
    retire("multu");

    // DIV -7 / 2
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 5'd3);
    wait_valid(lat);
    chk("div_lat", lat, 32);
    chk("div_hilo", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_we", {out_hilo_we, out_reg_we}, 2'b10);
    retire("div");

    // DIV 7 / -2 -> q=-3, r=1
    issue(F_DIV, 32'd7, 32'hFFFF_FFFE, 0, 0, 5'd4);
    wait_valid(lat);
    chk("div2_hilo", {out_hi, out_lo}, 64'h0000_0001_FFFF_FFFD);
    retire("div2");

    // DIV overflow case
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 5'd5);
    wait_valid(lat);
    chk("divovf_hilo", {out_hi, out_lo}, 64'h0000_0000_8000_0000);
    retire("divovf");

    // DIVU by zero
    issue(F_DIVU, 32'd7, 32'd0, 0, 0, 5'd6);
    wait_valid(lat);
    chk("divu0_lat", lat, 32);
    chk("divu0_hilo", {out_hi, out_lo}, 64'h0000_0007_FFFF_FFFF);
    retire("divu0");

    // DIV by zero, negative dividend
    issue(F_DIV, 32'hFFFF_FFFB, 32'd0, 0, 0, 5'd7);
    wait_valid(lat);
    chk("div0_hilo", {out_hi, out_lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    retire("div0");

    // MADD carry into HI
    issue(F_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd8);
    wait_valid(lat);
    chk("madd_lat", lat, 2);
    chk("madd_hilo", {out_hi, out_lo}, 64'h0000_0001_0000_0000);
    retire("madd");

    // MSUBU wraps
    issue(F_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 5'd10);
    wait_valid(lat);
    chk("msubu_hilo", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    retire("msubu");

    // MUL with backpressure
    issue(F_MUL, 32'd3, 32'd5, 0, 0, 5'd9);
    wait_valid(lat);
    chk("mul_lat", lat, 2);
    chk("mul_result", out_result, 15);
    chk("mul_we", {out_reg_we, out_hilo_we}, 2'b10);
    chk("mul_tag", out_tag, 9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", {out_result, out_tag, out_reg_we, out_hilo_we}, {32'd15, 5'd9, 2'b10});
      chk("hold_in_ready", in_ready, 0);
    end
    retire("mul");

    // Flush a DIV at cycle t+10
    issue(F_DIV, 32'd100, 32'd3, 0, 0, 5'd11);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("flush_no_valid", lat, 0);

    // Flush concurrent with offer: no accept
    @(negedge clk);
    in_funct = F_MUL; in_a = 32'd2; in_b = 32'd2; in_tag = 5'd12;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flushacc_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    chk("flushacc_no_valid", out_valid, 0);

    // Reset during MUL at t+1
    issue(F_MULT, 32'd6, 32'd7, 0, 0, 5'd13);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_outs", {out_valid, out_hi, out_lo, out_result, out_tag, out_reg_we, out_hilo_we}, '0);
    repeat (4) @(negedge clk);
    chk("midrst_no_valid", out_valid, 0);

    // Unsupported funct 0x00
    issue(6'h00, 32'd5, 32'd6, 32'd1, 32'd1, 5'd3);
    wait_valid(lat);
    chk("unsup_lat", lat, 0);
    chk("unsup_outs", {out_hi, out_lo, out_result, out_reg_we, out_hilo_we}, '0);
    chk("unsup_tag", out_tag, 3);
    retire("unsup");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
